// File: rtl/arbitro_fila_if.sv
// Handshake bundle between the requesters (A, B, D), the arbiter and the fila queue.
// master: the environment (producers, consumer, fila); slave: the arbiter itself.
interface arbitro_fila_if;
   logic       req_a_in;
   logic [7:0] data_a_in;
   logic       ack_a_out;
   logic       req_b_in;
   logic [7:0] data_b_in;
   logic       ack_b_out;
   logic       req_d_in;
   logic [7:0] dado_d_out;
   logic       ack_d_out;
   logic       err_d_out;
   logic       full_out;
   logic [7:0] fila_data_out;
   logic       fila_enqueue_out;
   logic       fila_dequeue_out;
   logic [7:0] fila_data_in;
   logic [7:0] fila_len_in;

   modport master (
      output req_a_in, data_a_in, req_b_in, data_b_in, req_d_in, fila_data_in, fila_len_in,
      input  ack_a_out, ack_b_out, dado_d_out, ack_d_out, err_d_out, full_out,
      input  fila_data_out, fila_enqueue_out, fila_dequeue_out
   );

   modport slave (
      input  req_a_in, data_a_in, req_b_in, data_b_in, req_d_in, fila_data_in, fila_len_in,
      output ack_a_out, ack_b_out, dado_d_out, ack_d_out, err_d_out, full_out,
      output fila_data_out, fila_enqueue_out, fila_dequeue_out
   );
endinterface

// File: rtl/arbitro_fila.sv
// Round-robin arbiter sharing the single fila enqueue/dequeue port among producers A, B
// and consumer D; one queue operation per OCIOSO -> op -> ESPERA round.
module arbitro_fila #(
   parameter int unsigned DEPTH = 8
) (
   input logic           clk_10KHz,
   input logic           reset,
   arbitro_fila_if.slave bus
);

   typedef enum logic [2:0] {
      StOcioso,
      StEnfileira,
      StDesenfileira,
      StErro,
      StEspera
   } state_e;

   typedef enum logic [1:0] {
      SelA = 2'd0,
      SelB = 2'd1,
      SelD = 2'd2
   } sel_e;

   state_e     state_q, state_d;
   sel_e       last_q, last_d;
   logic       src_b_q, src_b_d;
   logic [7:0] fdata_q, fdata_d;
   logic [7:0] dado_q, dado_d;
   logic       full_q, full_d;

   logic elig_a, elig_b, elig_d;
   logic gnt_valid;
   sel_e gnt;
   logic ack_a, ack_b, ack_d, err_d, enq, deq;

   assign elig_a = bus.req_a_in & ~full_q;
   assign elig_b = bus.req_b_in & ~full_q;
   assign elig_d = bus.req_d_in;

   // Rotation starts just after the last grantee: A -> B -> D -> A.
   always_comb begin
      gnt_valid = 1'b0;
      gnt       = SelA;
      unique case (last_q)
         SelA: begin
            if (elig_b)      begin gnt_valid = 1'b1; gnt = SelB; end
            else if (elig_d) begin gnt_valid = 1'b1; gnt = SelD; end
            else if (elig_a) begin gnt_valid = 1'b1; gnt = SelA; end
         end
         SelB: begin
            if (elig_d)      begin gnt_valid = 1'b1; gnt = SelD; end
            else if (elig_a) begin gnt_valid = 1'b1; gnt = SelA; end
            else if (elig_b) begin gnt_valid = 1'b1; gnt = SelB; end
         end
         SelD: begin
            if (elig_a)      begin gnt_valid = 1'b1; gnt = SelA; end
            else if (elig_b) begin gnt_valid = 1'b1; gnt = SelB; end
            else if (elig_d) begin gnt_valid = 1'b1; gnt = SelD; end
         end
         default: begin
            gnt_valid = 1'b0;
            gnt       = SelA;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      src_b_d = src_b_q;
      fdata_d = fdata_q;
      dado_d  = dado_q;
      full_d  = 32'(bus.fila_len_in) >= DEPTH;
      ack_a   = 1'b0;
      ack_b   = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      enq     = 1'b0;
      deq     = 1'b0;
      unique case (state_q)
         StOcioso: begin
            if (gnt_valid) begin
               last_d = gnt;
               unique case (gnt)
                  SelA: begin
                     state_d = StEnfileira;
                     src_b_d = 1'b0;
                     fdata_d = bus.data_a_in;
                  end
                  SelB: begin
                     state_d = StEnfileira;
                     src_b_d = 1'b1;
                     fdata_d = bus.data_b_in;
                  end
                  default: begin
                     // Head is captured before removal so it is valid during the ack cycle.
                     if (bus.fila_len_in != 8'd0) begin
                        state_d = StDesenfileira;
                        dado_d  = bus.fila_data_in;
                     end else begin
                        state_d = StErro;
                     end
                  end
               endcase
            end
         end
         StEnfileira: begin
            enq     = 1'b1;
            ack_a   = ~src_b_q;
            ack_b   = src_b_q;
            state_d = StEspera;
         end
         StDesenfileira: begin
            deq     = 1'b1;
            ack_d   = 1'b1;
            state_d = StEspera;
         end
         StErro: begin
            err_d   = 1'b1;
            state_d = StEspera;
         end
         StEspera: state_d = StOcioso;
         default:  state_d = StOcioso;
      endcase
   end

   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
         state_q <= StOcioso;
         last_q  <= SelD;
         src_b_q <= 1'b0;
         fdata_q <= 8'h00;
         dado_q  <= 8'h00;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         src_b_q <= src_b_d;
         fdata_q <= fdata_d;
         dado_q  <= dado_d;
         full_q  <= full_d;
      end
   end

   assign bus.ack_a_out        = ack_a;
   assign bus.ack_b_out        = ack_b;
   assign bus.ack_d_out        = ack_d;
   assign bus.err_d_out        = err_d;
   assign bus.dado_d_out       = dado_q;
   assign bus.full_out         = full_q;
   assign bus.fila_data_out    = fdata_q;
   assign bus.fila_enqueue_out = enq;
   assign bus.fila_dequeue_out = deq;

endmodule

// File: tb/tb_arbitro_fila.sv
// Bench for arbitro_fila: a fila queue model, a transaction-level round-robin reference,
// directed scenarios and a randomized request phase.
`timescale 1us / 1ns
module tb_arbitro_fila;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   arbitro_fila_if bus ();

   arbitro_fila #(.DEPTH(8)) dut (
      .clk_10KHz (clk),
      .reset     (rst_n),
      .bus       (bus)
   );

   always #50 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // fila model: strobes sampled mid-cycle, applied on the rising edge.
   logic [7:0] fq[$];
   logic       pend_enq = 1'b0, pend_deq = 1'b0;
   logic [7:0] pend_data = 8'h00;
   always @(negedge clk) begin
      pend_enq  = bus.fila_enqueue_out;
      pend_deq  = bus.fila_dequeue_out;
      pend_data = bus.fila_data_out;
   end
   always @(posedge clk) begin
      if (pend_enq) fq.push_back(pend_data);
      if (pend_deq && fq.size() != 0) fq.delete(0);
      bus.fila_len_in  <= 8'(fq.size());
      bus.fila_data_in <= (fq.size() != 0) ? fq[0] : 8'h00;
   end

   // Reference model state
   logic [7:0] refq[$];
   int         last_m = 2;  // 0=A 1=B 2=D
   int         gap = 1;
   logic       p_a = 0, p_b = 0, p_d = 0;
   logic [7:0] exp_dado = 8'h00;
   int         len_last = 0;

   // Last monitored sample
   logic       m_ack_a, m_ack_d, m_err_d, m_enq, m_deq, m_full;
   logic [7:0] m_dado, m_fdata;
   int         m_who = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic el[3];
      logic grant, any, full_ref;
      int   pred, c;
      m_ack_a = bus.ack_a_out;
      m_ack_d = bus.ack_d_out;
      m_err_d = bus.err_d_out;
      m_enq   = bus.fila_enqueue_out;
      m_deq   = bus.fila_dequeue_out;
      m_full  = bus.full_out;
      m_dado  = bus.dado_d_out;
      m_fdata = bus.fila_data_out;
      m_who   = -1;
      if (!rst_n) begin
         chk("rst_outs", {bus.ack_a_out, bus.ack_b_out, bus.ack_d_out, bus.err_d_out,
                          bus.fila_enqueue_out, bus.fila_dequeue_out, bus.full_out}, 0);
         chk("rst_dado", bus.dado_d_out, 0);
         chk("rst_fdata", bus.fila_data_out, 0);
         last_m = 2; gap = 1; p_a = 0; p_b = 0; p_d = 0; exp_dado = 8'h00; len_last = 0;
         return;
      end
      gap++;
      chk("enq_deq_excl", bus.fila_enqueue_out & bus.fila_dequeue_out, 0);
      chk("enq_vs_ack", bus.fila_enqueue_out, bus.ack_a_out | bus.ack_b_out);
      chk("deq_vs_ack", bus.fila_dequeue_out, bus.ack_d_out);
      chk("one_grant", $countones({bus.ack_a_out, bus.ack_b_out, bus.ack_d_out,
                                   bus.err_d_out}) <= 1, 1);
      chk("full_out", bus.full_out, len_last >= 8);
      full_ref = refq.size() >= 8;
      el[0] = p_a && !full_ref;
      el[1] = p_b && !full_ref;
      el[2] = p_d;
      any = el[0] | el[1] | el[2];
      pred = -1;
      for (int k = 1; k <= 3; k++) begin
         c = (last_m + k) % 3;
         if (pred < 0 && el[c]) pred = c;
      end
      grant = bus.ack_a_out | bus.ack_b_out | bus.ack_d_out | bus.err_d_out;
      chk("grant_when_due", grant, (gap >= 3) && any);
      if (grant) begin
         if (bus.ack_a_out) m_who = 0;
         else if (bus.ack_b_out) m_who = 1;
         else m_who = 2;
         chk("rr_order", m_who, pred);
         last_m = m_who;
         gap = 0;
         if (bus.ack_a_out) begin
            chk("enq_data_a", bus.fila_data_out, bus.data_a_in);
            refq.push_back(bus.data_a_in);
         end
         if (bus.ack_b_out) begin
            chk("enq_data_b", bus.fila_data_out, bus.data_b_in);
            refq.push_back(bus.data_b_in);
         end
         if (bus.ack_d_out) begin
            chk("deq_nonempty", refq.size() != 0, 1);
            if (refq.size() != 0) exp_dado = refq.pop_front();
         end
         if (bus.err_d_out) chk("err_empty", refq.size(), 0);
      end else begin
         chk("len_track", bus.fila_len_in, refq.size());
      end
      chk("dado_out", bus.dado_d_out, exp_dado);
      len_last = int'(bus.fila_len_in);
      p_a = bus.req_a_in;
      p_b = bus.req_b_in;
      p_d = bus.req_d_in;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string tag, input int maxc, output int who);
      who = -1;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (m_who >= 0) begin
            who = m_who;
            break;
         end
      end
      chk({tag, "_timeout"}, who != -1, 1);
   endtask

   initial begin
      int who, na, nb, cnt;
      bus.req_a_in = 0; bus.req_b_in = 0; bus.req_d_in = 0;
      bus.data_a_in = 8'h00; bus.data_b_in = 8'h00;
      repeat (3) step();
      rst_n = 1;

      // A alone sends 0x11
      bus.data_a_in = 8'h11; bus.req_a_in = 1;
      step();
      chk("t1_no_early_ack", m_ack_a, 0);
      step();
      chk("t1_ack_a", m_ack_a, 1);
      chk("t1_enq", m_enq, 1);
      chk("t1_fdata", m_fdata, 8'h11);
      bus.req_a_in = 0;
      step();
      chk("t1_len", bus.fila_len_in, 1);
      bus.req_d_in = 1;
      wait_grant("t1_deq", 6, who);
      chk("t1_deq_who", who, 2);
      chk("t1_dado", m_dado, 8'h11);
      bus.req_d_in = 0;

      // A and B held continuously until full
      na = 0; nb = 0;
      bus.data_a_in = 8'hA0; bus.data_b_in = 8'hB0;
      bus.req_a_in = 1; bus.req_b_in = 1;
      for (int i = 0; i < 8; i++) begin
         wait_grant("t2_enq", 6, who);
         chk("t2_alt", who, i % 2);
         if (who == 0) begin na++; bus.data_a_in = 8'(8'hA0 + na); end
         else if (who == 1) begin nb++; bus.data_b_in = 8'(8'hB0 + nb); end
      end
      step(); step();
      chk("t2_full", m_full, 1);
      cnt = 0;
      repeat (20) begin
         step();
         if (m_enq || m_who >= 0) cnt++;
      end
      chk("t2_stall", cnt, 0);
      bus.req_a_in = 0; bus.req_b_in = 0;

      // Drain in order, then one dequeue too many
      bus.req_d_in = 1;
      for (int i = 0; i < 8; i++) begin
         wait_grant("t3_deq", 6, who);
         chk("t3_who", who, 2);
         chk("t3_dado", m_dado, (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2));
      end
      wait_grant("t3_err", 6, who);
      chk("t3_err", m_err_d, 1);
      chk("t3_no_deq", m_deq, 0);
      bus.req_d_in = 0;

      // A, B, D together right after reset
      rst_n = 0;
      step();
      rst_n = 1;
      bus.data_a_in = 8'hC1; bus.data_b_in = 8'hC2;
      bus.req_a_in = 1; bus.req_b_in = 1; bus.req_d_in = 1;
      for (int i = 0; i < 3; i++) begin
         wait_grant("t4", 6, who);
         chk("t4_order", who, i);
         if (who == 0) bus.req_a_in = 0;
         if (who == 1) bus.req_b_in = 0;
         if (who == 2) begin chk("t4_dado", m_dado, 8'hC1); bus.req_d_in = 0; end
      end
      bus.req_d_in = 1;
      wait_grant("t4_drain", 6, who);
      chk("t4_dado2", m_dado, 8'hC2);
      bus.req_d_in = 0;

      // Fill with 0x11..0x88, A stalls on full, D unblocks it
      bus.req_a_in = 1;
      for (int i = 0; i < 8; i++) begin
         bus.data_a_in = 8'(8'h11 * (i + 1));
         wait_grant("t5_fill", 6, who);
         chk("t5_fill_who", who, 0);
      end
      bus.data_a_in = 8'h99;
      cnt = 0;
      repeat (6) begin
         step();
         if (m_who >= 0) cnt++;
      end
      chk("t5_stalled", cnt, 0);
      bus.req_d_in = 1;
      wait_grant("t5_d", 6, who);
      chk("t5_d_who", who, 2);
      chk("t5_d_dado", m_dado, 8'h11);
      bus.req_d_in = 0;
      step();
      chk("t5_len7", bus.fila_len_in, 7);
      wait_grant("t5_a", 6, who);
      chk("t5_a_after_d", who, 0);
      bus.req_a_in = 0;
      step();
      chk("t5_len8", bus.fila_len_in, 8);
      bus.req_d_in = 1;
      for (int i = 1; i < 9; i++) begin
         wait_grant("t5_drain", 6, who);
         chk("t5_drain_dado", m_dado, (i < 8) ? 8'(8'h11 * (i + 1)) : 8'h99);
      end
      wait_grant("t5_err", 6, who);
      chk("t5_err", m_err_d, 1);
      bus.req_d_in = 0;

      // Reset asserted while A is in ENFILEIRA
      step(); step();
      bus.data_a_in = 8'h5A; bus.data_b_in = 8'h6B;
      bus.req_a_in = 1; bus.req_b_in = 1;
      step();
      chk("t6_in_enf", bus.fila_enqueue_out, 1);
      rst_n = 0;
      #1;
      chk("t6_rst_ack", bus.ack_a_out, 0);
      chk("t6_rst_enq", bus.fila_enqueue_out, 0);
      chk("t6_rst_dado", bus.dado_d_out, 0);
      step(); step();
      rst_n = 1;
      wait_grant("t6_a", 6, who);
      chk("t6_a_first", who, 0);
      chk("t6_fdata", m_fdata, 8'h5A);
      bus.req_a_in = 0;
      wait_grant("t6_b", 6, who);
      chk("t6_b_next", who, 1);
      bus.req_b_in = 0;
      bus.req_d_in = 1;
      wait_grant("t6_d1", 6, who);
      chk("t6_dado1", m_dado, 8'h5A);
      wait_grant("t6_d2", 6, who);
      chk("t6_dado2", m_dado, 8'h6B);
      bus.req_d_in = 0;

      // Randomized requests; the monitor carries all checking
      repeat (900) begin
         step();
         if (m_who == 0) bus.req_a_in = 0;
         else if (!bus.req_a_in && $urandom_range(0, 2) == 0) begin
            bus.req_a_in = 1; bus.data_a_in = 8'($urandom);
         end
         if (m_who == 1) bus.req_b_in = 0;
         else if (!bus.req_b_in && $urandom_range(0, 2) == 0) begin
            bus.req_b_in = 1; bus.data_b_in = 8'($urandom);
         end
         if (m_who == 2) bus.req_d_in = 0;
         else if (!bus.req_d_in && $urandom_range(0, 4) == 0) bus.req_d_in = 1;
      end
      // Let any granted transaction finish before dropping the levels
      cnt = 0;
      while ((bus.req_a_in || bus.req_b_in || bus.req_d_in) && cnt < 60) begin
         step();
         if (m_who == 0) bus.req_a_in = 0;
         if (m_who == 1) bus.req_b_in = 0;
         if (m_who == 2) bus.req_d_in = 0;
         if (bus.full_out) begin bus.req_a_in = 0; bus.req_b_in = 0; end
         cnt++;
      end
      chk("rand_settle", cnt < 60, 1);
      repeat (6) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
